reg_scoreboard: RTL and testbench

Parametrised register-file write tracker for the pipelined CPU. It decodes writeback addresses into a registered one-hot write-enable bus for the register file. It also keeps a per-register count of in-flight writes so decode can detect RAW hazards and stall on write-after-write saturation. It sits between decode/issue (`issue_*`, `rd_addr_*`) and writeback (`wb_*`), and feeds `wr_en` to the register file.

---
 rtl/reg_pkg.sv | 11 +
 rtl/onehot_decoder.sv | 19 +
 rtl/reg_scoreboard.sv | 95 +++++++++
 tb/tb_reg_scoreboard.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-file constants and address type.
// Used by decode, scoreboard and register file.
package reg_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/onehot_decoder.sv
// Enable-gated binary to one-hot decoder.
// Ports: en, in (ADDR_W); out (NUM_OUT), zero if in >= NUM_OUT.
module onehot_decoder #(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] in,
  output logic [NUM_OUT-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (en && in == ADDR_W'(i)) out[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register write tracker: per-register pending counts and one-hot wr_en.
// Ports: issue_*, wb_*, rd_addr_a/b in; issue_ready, hazard_a/b, busy, wr_en, err_underflow out.
module reg_scoreboard #(
  parameter int NUM_REGS = reg_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_pkg::ADDR_W,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = reg_pkg::ZERO_REG
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] wr_en,
  output logic                err_underflow
);

  import reg_pkg::*;

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  logic [NUM_REGS-1:0] iss_oh;
  logic [NUM_REGS-1:0] wb_oh;
  logic [NUM_REGS-1:0] fire;
  logic [NUM_REGS-1:0] sat;
  logic [NUM_REGS-1:0] uf;
  logic [CNT_W-1:0]    cnt [NUM_REGS];

  // Issue decode ignores issue_valid so that ready
  // depends only on the address and registered counts.
  onehot_decoder #(
    .ADDR_W (ADDR_W),
    .NUM_OUT(NUM_REGS)
  ) u_iss_dec (
    .en (issue_addr != ZR),
    .in (issue_addr),
    .out(iss_oh)
  );

  onehot_decoder #(
    .ADDR_W (ADDR_W),
    .NUM_OUT(NUM_REGS)
  ) u_wb_dec (
    .en (wb_valid && wb_addr != ZR),
    .in (wb_addr),
    .out(wb_oh)
  );

  assign issue_ready = ~|(iss_oh & sat);
  assign fire = iss_oh & {NUM_REGS{issue_valid & issue_ready}};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign busy[i] = cnt[i] != '0;
    assign sat[i]  = cnt[i] == CMAX;
    assign uf[i]   = wb_oh[i] & ~fire[i] & ~busy[i];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt[i] <= '0;
      end else if (fire[i] && !wb_oh[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (wb_oh[i] && !fire[i] && busy[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) hazard_a = busy[i];
      if (rd_addr_b == ADDR_W'(i)) hazard_b = busy[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en         <= '0;
      err_underflow <= 1'b0;
    end else begin
      wr_en         <= wb_oh;
      err_underflow <= err_underflow | (|uf);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard.
// Drives vectors after each edge, checks #1 after the edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic        hazard_a;
  logic        hazard_b;
  logic [31:0] busy;
  logic [31:0] wr_en;
  logic        err_underflow;

  int total = 0;
  int bad = 0;

  reg_scoreboard dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .hazard_a     (hazard_a),
    .hazard_b     (hazard_b),
    .busy         (busy),
    .wr_en        (wr_en),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    cyc();
    cyc();
    issue_addr = 5'd3;
    rd_addr_a  = 5'd3;
    rd_addr_b  = 5'd4;
    #1;
    total++;
    if (busy !== 32'h0) begin
      bad++;
      $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0);
    end
    total++;
    if (wr_en !== 32'h0) begin
      bad++;
      $display("FAIL reset_wr_en got=%h exp=%h", wr_en, 32'h0);
    end
    total++;
    if ({issue_ready, hazard_a, hazard_b, err_underflow} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=%b",
        {issue_ready, hazard_a, hazard_b, err_underflow}, 4'b1000);
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    rd_addr_a   = 5'd3;
    rd_addr_b   = 5'd4;
    cyc();
    idle();
    #1;
    total++;
    if (busy !== 32'h0000_0008) begin
      bad++;
      $display("FAIL basic_busy got=%h exp=%h", busy, 32'h8);
    end
    total++;
    if ({hazard_a, hazard_b} !== 2'b10) begin
      bad++;
      $display("FAIL basic_hazard got=%b exp=%b", {hazard_a, hazard_b}, 2'b10);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    cyc();
    idle();
    total++;
    if (wr_en !== 32'h0000_0008 || busy !== 32'h0) begin
      bad++;
      $display("FAIL basic_wb got=%h/%h exp=%h/%h", wr_en, busy, 32'h8, 32'h0);
    end
    total++;
    if (hazard_a !== 1'b0) begin
      bad++;
      $display("FAIL basic_hazard_clr got=%b exp=%b", hazard_a, 1'b0);
    end
    cyc();
    total++;
    if (wr_en !== 32'h0) begin
      bad++;
      $display("FAIL basic_wr_en_pulse got=%h exp=%h", wr_en, 32'h0);
    end
  endtask

  task automatic test_saturate();
    issue_addr  = 5'd5;
    issue_valid = 1'b1;
    cyc();
    cyc();
    cyc();
    idle();
    #1;
    total++;
    if (issue_ready !== 1'b0) begin
      bad++;
      $display("FAIL sat_ready5 got=%b exp=%b", issue_ready, 1'b0);
    end
    issue_addr = 5'd6;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL sat_ready6 got=%b exp=%b", issue_ready, 1'b1);
    end
    issue_addr  = 5'd5;
    issue_valid = 1'b1;
    cyc();
    idle();
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    cyc();
    total++;
    if (issue_ready !== 1'b1 || busy[5] !== 1'b1) begin
      bad++;
      $display("FAIL sat_after_wb got=%b%b exp=11", issue_ready, busy[5]);
    end
    cyc();
    total++;
    if (busy[5] !== 1'b1) begin
      bad++;
      $display("FAIL sat_cnt1 got=%b exp=%b", busy[5], 1'b1);
    end
    cyc();
    idle();
    total++;
    if (busy[5] !== 1'b0 || err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL sat_drain got=%b%b exp=00", busy[5], err_underflow);
    end
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    cyc();
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0000_0080 || wr_en !== 32'h0000_0080) begin
      bad++;
      $display("FAIL same_x7 got=%h/%h exp=%h/%h", busy, wr_en, 32'h80, 32'h80);
    end
    wb_valid = 1'b1;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0) begin
      bad++;
      $display("FAIL same_x7_drain got=%h exp=%h", busy, 32'h0);
    end
    issue_valid = 1'b1;
    issue_addr  = 5'd10;
    wb_valid    = 1'b1;
    wb_addr     = 5'd10;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0 || wr_en !== 32'h0000_0400 || err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL same_x10 got=%h/%h/%b exp=%h/%h/0",
        busy, wr_en, err_underflow, 32'h0, 32'h400);
    end
  endtask

  task automatic test_zero_reg();
    issue_valid = 1'b1;
    issue_addr  = 5'd31;
    wb_valid    = 1'b1;
    wb_addr     = 5'd31;
    rd_addr_a   = 5'd31;
    rd_addr_b   = 5'd31;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0 || wr_en !== 32'h0) begin
      bad++;
      $display("FAIL zero_state got=%h/%h exp=0/0", busy, wr_en);
    end
    total++;
    if ({issue_ready, hazard_a, hazard_b} !== 3'b100) begin
      bad++;
      $display("FAIL zero_flags got=%b exp=%b",
        {issue_ready, hazard_a, hazard_b}, 3'b100);
    end
  endtask

  task automatic test_underflow();
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    cyc();
    idle();
    total++;
    if (err_underflow !== 1'b1 || wr_en !== 32'h0000_0200 || busy !== 32'h0) begin
      bad++;
      $display("FAIL uf_set got=%b/%h/%h exp=1/%h/0",
        err_underflow, wr_en, busy, 32'h200);
    end
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    cyc();
    idle();
    total++;
    if (err_underflow !== 1'b1 || wr_en !== 32'h0 || busy !== 32'h0000_0200) begin
      bad++;
      $display("FAIL uf_hold got=%b/%h/%h exp=1/0/%h",
        err_underflow, wr_en, busy, 32'h200);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0 || err_underflow !== 1'b1) begin
      bad++;
      $display("FAIL uf_drain got=%h/%b exp=0/1", busy, err_underflow);
    end
  endtask

  task automatic test_reset_mid();
    rd_addr_a   = 5'd1;
    rd_addr_b   = 5'd2;
    issue_valid = 1'b1;
    issue_addr  = 5'd1;
    cyc();
    issue_addr = 5'd2;
    cyc();
    issue_addr = 5'd4;
    wb_valid   = 1'b1;
    wb_addr    = 5'd12;
    cyc();
    idle();
    total++;
    if (busy !== 32'h0000_0016 || wr_en !== 32'h0000_1000 ||
        {hazard_a, hazard_b} !== 2'b11) begin
      bad++;
      $display("FAIL mid_pre got=%h/%h/%b exp=%h/%h/11",
        busy, wr_en, {hazard_a, hazard_b}, 32'h16, 32'h1000);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 32'h0 || wr_en !== 32'h0 || err_underflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got=%h/%h/%b exp=0/0/0", busy, wr_en, err_underflow);
    end
    total++;
    if ({issue_ready, hazard_a, hazard_b} !== 3'b100) begin
      bad++;
      $display("FAIL mid_flags got=%b exp=%b",
        {issue_ready, hazard_a, hazard_b}, 3'b100);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    total++;
    if (busy !== 32'h0) begin
      bad++;
      $display("FAIL mid_after got=%h exp=%h", busy, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_same_cycle();
    test_zero_reg();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
